// File: rtl/listing_loader.sv
// Listing loader: copies an integer listing into target memory, either as
// (addr,data) pairs or as a contiguous block at BASE_ADDR, while holding the CPU.
module listing_loader #(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       SRC_W     = 32,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0200
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         mode,
    input  logic [$clog2(DEPTH+1)-1:0]   len,
    output logic                         src_rd_en,
    output logic [$clog2(DEPTH)-1:0]     src_rd_addr,
    input  logic [SRC_W-1:0]             src_rd_data,
    output logic                         mem_wr_en,
    output logic [ADDR_W-1:0]            mem_wr_addr,
    output logic [DATA_W-1:0]            mem_wr_data,
    input  logic                         mem_wr_ready,
    output logic                         busy,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SUM_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] ADDR_MAX = SUM_W'({ADDR_W{1'b1}});

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LAT  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rd_en_q, rd_en_d;
    logic [IDX_W-1:0]    rd_addr_q, rd_addr_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [SUM_W-1:0]    contig_sum_c;
    logic                ovf_c;
    logic                pair_addr_c;
    logic                bad_len_c;
    logic                unused_c;

    // Upper listing bits beyond the address/data fields carry no meaning here.
    assign unused_c = ^src_rd_data;

    assign contig_sum_c = SUM_W'(BASE_ADDR) + SUM_W'(wcnt_q);
    assign ovf_c        = (contig_sum_c > ADDR_MAX);
    assign pair_addr_c  = !mode_q && !idx_q[0];
    assign bad_len_c    = !mode && len[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((len == '0) || bad_len_c) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:  state_d = ST_LAT;
            ST_LAT: begin
                if (pair_addr_c) begin
                    state_d = ST_RD;
                end else if (mode_q && ovf_c) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (mem_wr_ready) begin
                    state_d = (idx_q == len_q) ? ST_FIN : ST_RD;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; outputs follow the state being entered
    always_comb begin
        mode_d = mode_q;
        len_d  = len_q;
        idx_d  = idx_q;
        wcnt_d = wcnt_q;
        err_d  = err_q;
        addr_d = addr_q;
        data_d = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    len_d  = len;
                    idx_d  = '0;
                    wcnt_d = '0;
                    err_d  = bad_len_c;
                end
            end
            ST_LAT: begin
                if (pair_addr_c) begin
                    addr_d = src_rd_data[ADDR_W-1:0];
                    idx_d  = idx_q + CNT_W'(1);
                end else if (mode_q && ovf_c) begin
                    err_d = 1'b1;
                end else begin
                    data_d = src_rd_data[DATA_W-1:0];
                    idx_d  = idx_q + CNT_W'(1);
                    if (mode_q) begin
                        addr_d = contig_sum_c[ADDR_W-1:0];
                    end
                end
            end
            ST_WR: begin
                if (mem_wr_ready) begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase

        rd_en_d   = (state_d == ST_RD);
        rd_addr_d = (state_d == ST_RD) ? idx_d[IDX_W-1:0] : '0;
        wr_en_d   = (state_d == ST_WR);
        done_d    = (state_d == ST_FIN);
        busy_d    = (state_d != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            wcnt_q    <= wcnt_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign src_rd_en   = rd_en_q;
    assign src_rd_addr = rd_addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;
    assign busy        = busy_q;
    assign cpu_hold    = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_listing_loader.sv
// Bench for listing_loader: directed scenarios plus randomized loads checked
// against a listing-level model of the expected writes, error and latency.
module tb_listing_loader;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SRC_W  = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned LEN_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W  = $clog2(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic mode  = 1'b0;
    logic ready = 1'b1;
    logic [LEN_W-1:0] len = '0;
    logic sel_b = 1'b0;

    logic              a_rd_en, b_rd_en;
    logic [IDX_W-1:0]  a_rd_addr, b_rd_addr;
    logic [SRC_W-1:0]  a_rd_data, b_rd_data;
    logic              a_wr_en, b_wr_en;
    logic [ADDR_W-1:0] a_wr_addr, b_wr_addr;
    logic [DATA_W-1:0] a_wr_data, b_wr_data;
    logic              a_busy, b_busy, a_hold, b_hold, a_done, b_done, a_err, b_err;

    logic [SRC_W-1:0] src_mem [DEPTH];
    logic [23:0]      got_q [$];
    logic [23:0]      exp_q [$];
    int               stall_arr [16];
    int               base_n = 0;
    int               stall_cyc = 0;
    int               stall_viol = 0;
    int               n_chk = 0;
    int               n_err = 0;

    listing_loader #(.BASE_ADDR(16'h0200)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .len(len),
        .src_rd_en(a_rd_en), .src_rd_addr(a_rd_addr), .src_rd_data(a_rd_data),
        .mem_wr_en(a_wr_en), .mem_wr_addr(a_wr_addr), .mem_wr_data(a_wr_data),
        .mem_wr_ready(ready), .busy(a_busy), .cpu_hold(a_hold), .done(a_done), .err(a_err)
    );

    listing_loader #(.BASE_ADDR(16'hFFFE)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .len(len),
        .src_rd_en(b_rd_en), .src_rd_addr(b_rd_addr), .src_rd_data(b_rd_data),
        .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data),
        .mem_wr_ready(ready), .busy(b_busy), .cpu_hold(b_hold), .done(b_done), .err(b_err)
    );

    logic              act_wr_en, act_busy, act_hold, act_done, act_err;
    logic [ADDR_W-1:0] act_wr_addr;
    logic [DATA_W-1:0] act_wr_data;
    assign act_wr_en   = sel_b ? b_wr_en   : a_wr_en;
    assign act_wr_addr = sel_b ? b_wr_addr : a_wr_addr;
    assign act_wr_data = sel_b ? b_wr_data : a_wr_data;
    assign act_busy    = sel_b ? b_busy    : a_busy;
    assign act_hold    = sel_b ? b_hold    : a_hold;
    assign act_done    = sel_b ? b_done    : a_done;
    assign act_err     = sel_b ? b_err     : a_err;

    always #5 clk = ~clk;

    // Listing RAM with one-cycle read latency
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= src_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= src_mem[b_rd_addr];
    end

    // Memory side: ready held low for stall_arr[k] WR cycles on the k-th write
    int wait_cnt = 0;
    always @(negedge clk) begin
        int cur;
        cur = got_q.size() - base_n;
        if (act_wr_en) begin
            if (cur < 16 && wait_cnt < stall_arr[cur]) begin
                ready = 1'b0;
                wait_cnt++;
            end else begin
                ready = 1'b1;
            end
        end else begin
            ready = 1'b1;
            wait_cnt = 0;
        end
    end

    // Write log and stall-stability monitor
    logic        stall_pend = 1'b0;
    logic [23:0] stall_snap = '0;
    always @(posedge clk) begin
        if (stall_pend && rst_n) begin
            if (!act_wr_en || {act_wr_addr, act_wr_data} != stall_snap) stall_viol++;
        end
        stall_pend = act_wr_en && !ready && rst_n;
        stall_snap = {act_wr_addr, act_wr_data};
        if (stall_pend) stall_cyc++;
        if (act_wr_en && ready) got_q.push_back({act_wr_addr, act_wr_data});
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Listing-level model: which writes happen, whether err is set, when done shows
    task automatic model(input bit use_b, input bit m, input int n,
                         output bit e_err, output int e_lat, output int e_stall);
        int base;
        base    = use_b ? 32'hFFFE : 32'h0200;
        e_err   = 1'b0;
        e_stall = 0;
        exp_q.delete();
        if (n == 0) begin
            e_lat = 1;
        end else if (!m && (n % 2 == 1)) begin
            e_err = 1'b1;
            e_lat = 1;
        end else if (!m) begin
            for (int i = 0; i < n / 2; i++) begin
                exp_q.push_back({src_mem[2*i][15:0], src_mem[2*i+1][7:0]});
                e_stall += stall_arr[i];
            end
            e_lat = 5 * (n / 2) + 1 + e_stall;
        end else begin
            e_lat = 3 * n + 1;
            for (int i = 0; i < n; i++) begin
                if (base + i > 32'hFFFF) begin
                    e_err = 1'b1;
                    e_lat = 3 * i + 3;
                    break;
                end
                exp_q.push_back({16'(base + i), src_mem[i][7:0]});
                e_stall += stall_arr[i];
            end
            e_lat += e_stall;
        end
    endtask

    task automatic run_load(input string nm, input bit use_b, input bit m, input int n);
        bit e_err;
        int e_lat, e_stall, cyc, st0;
        model(use_b, m, n, e_err, e_lat, e_stall);
        @(negedge clk);
        sel_b  = use_b;
        base_n = got_q.size();
        st0    = stall_cyc;
        stall_viol = 0;
        mode = m;
        len  = LEN_W'(n);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        mode = ~m;
        len  = LEN_W'(n + 1);
        check({nm, "_busy"}, act_busy, 1);
        check({nm, "_hold"}, act_hold, 1);
        while (!act_done && cyc < 2000) begin
            if (cyc == 2) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
        end
        check({nm, "_done_lat"}, cyc, e_lat);
        check({nm, "_err"}, act_err, e_err);
        @(negedge clk);
        check({nm, "_done_pulse"}, act_done, 0);
        check({nm, "_idle"}, act_busy, 0);
        check({nm, "_err_sticky"}, act_err, e_err);
        check({nm, "_nwr"}, got_q.size() - base_n, exp_q.size());
        check({nm, "_stall_cyc"}, stall_cyc - st0, e_stall);
        check({nm, "_stall_stable"}, stall_viol, 0);
        foreach (exp_q[i]) begin
            if (base_n + i < got_q.size()) check({nm, "_wr"}, got_q[base_n + i], exp_q[i]);
        end
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 16; i++) stall_arr[i] = 0;
    endtask

    initial begin
        int cyc, n0, dseen, n;
        bit m;
        for (int i = 0; i < DEPTH; i++) src_mem[i] = '0;
        clear_stalls();
        repeat (3) @(negedge clk);
        check("reset_outs", {a_rd_en, a_wr_en, a_busy, a_hold, a_done, a_err, a_wr_addr}, 0);
        rst_n = 1'b1;

        src_mem[0] = 32'hA2; src_mem[1] = 32'h00; src_mem[2] = 32'h8A;
        run_load("contig3", 1'b0, 1'b1, 3);
        check("contig3_w0", got_q[base_n], 24'h0200A2);

        src_mem[0] = 32'h1E; src_mem[1] = 32'hAA; src_mem[2] = 32'h1F; src_mem[3] = 32'hBB;
        run_load("pair4", 1'b0, 1'b0, 4);
        check("pair4_w1", got_q[base_n + 1], 24'h001FBB);

        stall_arr[0] = 4;
        run_load("bp2", 1'b0, 1'b1, 2);
        clear_stalls();

        run_load("pair_odd", 1'b0, 1'b0, 3);
        run_load("len0", 1'b0, 1'b1, 0);
        run_load("ovf3", 1'b1, 1'b1, 3);
        check("ovf3_w1", got_q[base_n + 1], {16'hFFFF, src_mem[1][7:0]});

        // Reset in the WR state of the second of five words
        for (int i = 0; i < 5; i++) src_mem[i] = $urandom;
        stall_arr[1] = 3;
        @(negedge clk);
        sel_b = 1'b0; base_n = got_q.size(); mode = 1'b1; len = LEN_W'(5); start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (!(a_wr_en && (got_q.size() - base_n == 1)) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach_wr2", cyc < 100, 1);
        rst_n = 1'b0;
        #1;
        check("rst_outs_mid", {a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_wr_data,
                               a_busy, a_hold, a_done, a_err}, 0);
        check("rst_nwr", got_q.size() - base_n, 1);
        n0 = got_q.size();
        clear_stalls();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dseen = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_done || a_busy) dseen++;
        end
        check("post_rst_nwr", got_q.size(), n0);
        check("post_rst_quiet", dseen, 0);
        run_load("reload5", 1'b0, 1'b1, 5);

        // Randomized loads on both origins
        for (int t = 0; t < 30; t++) begin
            m = 1'($urandom_range(0, 1));
            if (t % 5 == 4) begin
                n = $urandom_range(1, 4);
                m = 1'b1;
            end else if (m) begin
                n = $urandom_range(0, 10);
            end else begin
                n = (t % 7 == 3) ? 2 * $urandom_range(0, 5) + 1 : 2 * $urandom_range(0, 6);
            end
            for (int i = 0; i < 12; i++) src_mem[i] = $urandom;
            for (int i = 0; i < 16; i++) stall_arr[i] = $urandom_range(0, 2);
            run_load("rnd", t % 5 == 4, m, n);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
